// File: rtl/sd_response_checker.sv
// SD response checker: latches a 48-bit frame, recomputes CRC7 over [47:8] one bit per cycle, flags framing errors.
// Optional SD_RESP_CRC_IGNORE_EN adds crc_ignore to mask err_crc (R2/R3). Result is held until resp_ack.
module sd_response_checker #(
  parameter int WIDTH      = 64,
  parameter int FRAME_BITS = 48
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             complete,
  input  logic [WIDTH-1:0] parallel,
  input  logic             resp_ack,
`ifdef SD_RESP_CRC_IGNORE_EN
  input  logic             crc_ignore,
`endif
  output logic             resp_valid,
  output logic [5:0]       resp_index,
  output logic [31:0]      resp_arg,
  output logic             err_start,
  output logic             err_dir,
  output logic             err_end,
  output logic             err_crc,
  output logic             resp_error,
  output logic             busy,
  output logic             overrun
);

  localparam int         CRC_BITS = FRAME_BITS - 8;
  localparam logic [5:0] LAST_BIT = 6'(CRC_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [6:0]            crc_q, crc_d;
  logic [5:0]            cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [5:0]            index_q, index_d;
  logic [31:0]           arg_q, arg_d;
  logic                  es_q, es_d, ed_q, ed_d, ee_q, ee_d, ec_q, ec_d;
  logic                  overrun_q, overrun_d;
`ifdef SD_RESP_CRC_IGNORE_EN
  logic                  ign_q, ign_d;
`endif

  logic [FRAME_BITS-1:0] frame_w;
  logic                  fb_w;
  logic                  unused_upper;

  // The shift register rotates so that, after CRC_BITS rotations, the original frame is recoverable.
  assign frame_w      = {shift_q[CRC_BITS-1:0], shift_q[FRAME_BITS-1:CRC_BITS]};
  assign fb_w         = crc_q[6] ^ shift_q[FRAME_BITS-1];
  assign unused_upper = ^parallel[WIDTH-1:FRAME_BITS];

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    index_d   = index_q;
    arg_d     = arg_q;
    es_d      = es_q;
    ed_d      = ed_q;
    ee_d      = ee_q;
    ec_d      = ec_q;
    overrun_d = overrun_q;
`ifdef SD_RESP_CRC_IGNORE_EN
    ign_d     = ign_q;
`endif
    if (Enable) begin
      if (complete && state_q != S_IDLE) overrun_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (complete) begin
            shift_d = parallel[FRAME_BITS-1:0];
            crc_d   = 7'd0;
            cnt_d   = 6'd0;
`ifdef SD_RESP_CRC_IGNORE_EN
            ign_d   = crc_ignore;
`endif
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          crc_d   = {crc_q[5:3], crc_q[2] ^ fb_w, crc_q[1:0], fb_w};
          shift_d = {shift_q[FRAME_BITS-2:0], shift_q[FRAME_BITS-1]};
          if (cnt_q == LAST_BIT) state_d = S_CHECK;
          else                   cnt_d   = cnt_q + 6'd1;
        end
        S_CHECK: begin
          index_d = frame_w[FRAME_BITS-3 -: 6];
          arg_d   = frame_w[FRAME_BITS-9 -: 32];
          es_d    = frame_w[FRAME_BITS-1];
          ed_d    = frame_w[FRAME_BITS-2];
          ee_d    = ~frame_w[0];
          ec_d    = (crc_q != frame_w[7:1]);
`ifdef SD_RESP_CRC_IGNORE_EN
          if (ign_q) ec_d = 1'b0;
`endif
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
        default: begin
          if (resp_ack) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      crc_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      arg_q     <= '0;
      es_q      <= 1'b0;
      ed_q      <= 1'b0;
      ee_q      <= 1'b0;
      ec_q      <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SD_RESP_CRC_IGNORE_EN
      ign_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
      arg_q     <= arg_d;
      es_q      <= es_d;
      ed_q      <= ed_d;
      ee_q      <= ee_d;
      ec_q      <= ec_d;
      overrun_q <= overrun_d;
`ifdef SD_RESP_CRC_IGNORE_EN
      ign_q     <= ign_d;
`endif
    end
  end

  assign resp_valid = valid_q;
  assign resp_index = index_q;
  assign resp_arg   = arg_q;
  assign err_start  = es_q;
  assign err_dir    = ed_q;
  assign err_end    = ee_q;
  assign err_crc    = ec_q;
  assign resp_error = es_q | ed_q | ee_q | ec_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sd_response_checker.sv
// Directed bench for sd_response_checker: latency, field decode, error flags, overrun, reset and freeze.
module tb_sd_response_checker;
  logic        clk = 1'b0;
  logic        rst, en, complete, resp_ack;
  logic [63:0] parallel;
`ifdef SD_RESP_CRC_IGNORE_EN
  logic        crc_ignore;
`endif
  logic        resp_valid, err_start, err_dir, err_end, err_crc, resp_error, busy, overrun;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;

  int n_chk = 0;
  int n_err = 0;

  sd_response_checker dut (
    .Clock(clk), .Reset(rst), .Enable(en), .complete(complete), .parallel(parallel),
    .resp_ack(resp_ack),
`ifdef SD_RESP_CRC_IGNORE_EN
    .crc_ignore(crc_ignore),
`endif
    .resp_valid(resp_valid), .resp_index(resp_index), .resp_arg(resp_arg),
    .err_start(err_start), .err_dir(err_dir), .err_end(err_end), .err_crc(err_crc),
    .resp_error(resp_error), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [47:0] f);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 47; i >= 8; i--) begin
      fb = c[6] ^ f[i];
      c  = {c[5:3], c[2] ^ fb, c[1:0], fb};
    end
    return c;
  endfunction

  // Upper bits carry junk to show they are ignored.
  task automatic start_frame(input logic [47:0] f);
    @(negedge clk);
    parallel = {16'hDEAD, f};
    complete = 1'b1;
    @(negedge clk);
    complete = 1'b0;
    parallel = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic run_frame(input logic [47:0] f, input string tag);
    start_frame(f);
    repeat (40) @(negedge clk);
    chk({tag, "_pre"}, resp_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_lat"}, resp_valid, 1'b1);
  endtask

  task automatic check_res(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic es, input logic ed, input logic ee, input logic ec);
    chk({tag, "_idx"}, resp_index, idx);
    chk({tag, "_arg"}, resp_arg, arg);
    chk({tag, "_start"}, err_start, es);
    chk({tag, "_dir"}, err_dir, ed);
    chk({tag, "_end"}, err_end, ee);
    chk({tag, "_crc"}, err_crc, ec);
    chk({tag, "_rerr"}, resp_error, es | ed | ee | ec);
    chk({tag, "_busy"}, busy, 1'b1);
  endtask

  task automatic ack_result(input string tag, input logic [5:0] idx);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_hold"}, resp_valid, 1'b1);
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
    chk({tag, "_ackv"}, resp_valid, 1'b0);
    chk({tag, "_ackb"}, busy, 1'b0);
    chk({tag, "_keep"}, resp_index, idx);
  endtask

  task automatic watch_quiet(input string tag);
    int hits;
    hits = 0;
    repeat (50) begin
      @(negedge clk);
      if (resp_valid) hits++;
    end
    chk(tag, hits, 0);
  endtask

  logic [47:0] f6;

  initial begin
    rst = 1'b1; en = 1'b1; complete = 1'b0; resp_ack = 1'b0; parallel = '0;
`ifdef SD_RESP_CRC_IGNORE_EN
    crc_ignore = 1'b0;
`endif
    @(negedge clk);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_flags", {err_start, err_dir, err_end, err_crc, resp_error}, 5'b0);
    rst = 1'b0;

    // Frozen block ignores complete entirely.
    en = 1'b0;
    start_frame(48'h08000001AA13);
    @(negedge clk);
    chk("frz_busy", busy, 1'b0);
    chk("frz_ovr", overrun, 1'b0);
    en = 1'b1;

    run_frame(48'h08000001AA13, "t1");
    check_res("t1", 6'h08, 32'h000001AA, 1'b0, 1'b0, 1'b0, 1'b0);
    ack_result("t1", 6'h08);

    // Bit 1 flipped; also an ack during CALC must be ignored.
    start_frame(48'h08000001AA11);
    repeat (5) @(negedge clk);
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
    repeat (34) @(negedge clk);
    chk("t2_pre", resp_valid, 1'b0);
    @(negedge clk);
    chk("t2_lat", resp_valid, 1'b1);
    check_res("t2", 6'h08, 32'h000001AA, 1'b0, 1'b0, 1'b0, 1'b1);
    ack_result("t2", 6'h08);

    run_frame(48'h48000001AA87, "t3a");
    check_res("t3a", 6'h08, 32'h000001AA, 1'b0, 1'b1, 1'b0, 1'b0);
    ack_result("t3a", 6'h08);

    // End bit cleared; CRC field [7:1] is still correct. Three frozen edges with a complete inside.
    start_frame(48'h08000001AA12);
    repeat (9) @(negedge clk);
    en = 1'b0;
    complete = 1'b1;
    @(negedge clk);
    complete = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (31) @(negedge clk);
    chk("t3b_pre", resp_valid, 1'b0);
    @(negedge clk);
    chk("t3b_lat", resp_valid, 1'b1);
    chk("t3b_ovr", overrun, 1'b0);
    check_res("t3b", 6'h08, 32'h000001AA, 1'b0, 1'b0, 1'b1, 1'b0);
    ack_result("t3b", 6'h08);

    f6 = 48'h3F00FF8000FF;
`ifdef SD_RESP_CRC_IGNORE_EN
    crc_ignore = 1'b1;
    start_frame(f6);
    crc_ignore = 1'b0;
    repeat (40) @(negedge clk);
    chk("t6i_pre", resp_valid, 1'b0);
    @(negedge clk);
    chk("t6i_lat", resp_valid, 1'b1);
    check_res("t6i", 6'h3F, 32'h00FF8000, 1'b0, 1'b0, 1'b0, 1'b0);
    ack_result("t6i", 6'h3F);
`endif
    run_frame(f6, "t6");
    check_res("t6", 6'h3F, 32'h00FF8000, 1'b0, 1'b0, 1'b0, crc7(f6) != f6[7:1]);
    ack_result("t6", 6'h3F);

    // Second frame arrives at E20 of the first.
    start_frame(48'h08000001AA13);
    repeat (19) @(negedge clk);
    parallel = {16'h0, 48'h48000001AA87};
    complete = 1'b1;
    @(negedge clk);
    complete = 1'b0;
    chk("t4_ovr", overrun, 1'b1);
    repeat (20) @(negedge clk);
    chk("t4_pre", resp_valid, 1'b0);
    @(negedge clk);
    chk("t4_lat", resp_valid, 1'b1);
    check_res("t4", 6'h08, 32'h000001AA, 1'b0, 1'b0, 1'b0, 1'b0);
    ack_result("t4", 6'h08);
    watch_quiet("t4_single");

    // Reset in the middle of CALC.
    start_frame(48'h3F00FF8000FF);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_valid", resp_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_ovr", overrun, 1'b0);
    chk("t5_idx", resp_index, 6'h00);
    chk("t5_arg", resp_arg, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    watch_quiet("t5_quiet");
    run_frame(48'h48000001AA87, "t5b");
    check_res("t5b", 6'h08, 32'h000001AA, 1'b0, 1'b1, 1'b0, 1'b0);

    // complete and ack in the same HOLD cycle: ack wins, frame dropped.
    @(negedge clk);
    parallel = {16'h0, 48'h08000001AA13};
    complete = 1'b1;
    resp_ack = 1'b1;
    @(negedge clk);
    complete = 1'b0;
    resp_ack = 1'b0;
    chk("t7_valid", resp_valid, 1'b0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_ovr", overrun, 1'b1);
    watch_quiet("t7_quiet");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
